width_conv_fifo: RTL

WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

---
 rtl/width_conv_fifo_pkg.sv | 32 +++
 rtl/width_conv_fifo_ram.sv | 32 +++
 rtl/width_conv_fifo.sv | 137 +++++++++++++
 3 files changed

// File: rtl/width_conv_fifo_pkg.sv
// Shared mode encoding, clog2 helper and port-width derivations for the width converting FIFO.
// Latency: n/a (declarations only). Backpressure: n/a.
package width_conv_fifo_pkg;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Level width carries one extra bit so a completely full buffer (DEPTH) is representable.
    function automatic int lw_f(input int depth);
        return clog2_f(depth) + 1;
    endfunction

    function automatic int ww_f(input int narrow_w, input int ratio, input mode_e m);
        return (m == MODE_UP) ? narrow_w : narrow_w * ratio;
    endfunction

    function automatic int rw_f(input int narrow_w, input int ratio, input mode_e m);
        return (m == MODE_UP) ? narrow_w * ratio : narrow_w;
    endfunction

endpackage

// File: rtl/width_conv_fifo_ram.sv
// Single-clock simple dual-port RAM, registered read, write data forwarded on address collision.
// Latency: 1 cycle read. Backpressure: none, accepts a write and a read every cycle.
module width_conv_fifo_ram
    import width_conv_fifo_pkg::*;
#(
    parameter  int DEPTH = 512,
    parameter  int WIDTH = 128,
    localparam int AW    = clog2_f(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Forwarding lets a word written into an empty FIFO show up on the very next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n)                     rdata <= '0;
        else if (we && waddr == raddr)  rdata <= wdata;
        else                            rdata <= mem[raddr];
    end

endmodule

// File: rtl/width_conv_fifo.sv
// Width converting first-word-fall-through FIFO: packs narrow beats into wide words (UP) or unpacks wide words into narrow lanes (DOWN).
// Latency: committed word visible on rd_data 1 cycle after commit. Backpressure: wr_full / rd_empty from registered state, no pass-through.
module width_conv_fifo
    import width_conv_fifo_pkg::*;
#(
    parameter  int    NARROW_W = 16,
    parameter  int    RATIO    = 8,
    parameter  int    DEPTH    = 512,
    parameter  string MODE     = "UP",
    localparam mode_e MODE_E   = (MODE == "DOWN") ? MODE_DOWN : MODE_UP,
    localparam int    LW       = lw_f(DEPTH),
    localparam int    WW       = ww_f(NARROW_W, RATIO, MODE_E),
    localparam int    RW       = rw_f(NARROW_W, RATIO, MODE_E)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WW-1:0] wr_data,
    input  logic          wr_flush,
    output logic          wr_full,
    input  logic          rd_en,
    output logic [RW-1:0] rd_data,
    output logic          rd_empty,
    input  logic [LW-1:0] almost_full_th,
    input  logic [LW-1:0] almost_empty_th,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [LW-1:0] water_level,
    output logic          overflow,
    output logic          underflow
);

    localparam int              AW        = LW - 1;
    localparam int              WIDE_W    = NARROW_W * RATIO;
    localparam int              CW        = clog2_f(RATIO);
    localparam logic [LW-1:0]   DEPTH_L   = LW'(DEPTH);
    localparam logic [CW-1:0]   LAST_LANE = CW'(RATIO - 1);

    logic [LW-1:0]     wr_ptr, rd_ptr, mem_count;
    logic              full_mem, commit, pop, rd_acc;
    logic [WIDE_W-1:0] commit_word, ram_q;
    logic [AW-1:0]     rd_addr_nxt;

    assign full_mem     = (mem_count == DEPTH_L);
    assign rd_empty     = (mem_count == '0);
    assign rd_acc       = rd_en && !rd_empty;
    assign water_level  = mem_count;
    assign almost_full  = (mem_count >= almost_full_th);
    assign almost_empty = (mem_count <= almost_empty_th);

    // The RAM is addressed with the post-pop pointer so its registered output tracks the head word.
    assign rd_addr_nxt  = pop ? (rd_ptr[AW-1:0] + AW'(1)) : rd_ptr[AW-1:0];

    if (MODE_E == MODE_UP) begin : gen_up
        logic [CW-1:0]     pack_cnt;
        logic [WIDE_W-1:0] pack_buf, pack_nxt;
        logic              beat_acc, flush_acc;

        // Beats keep landing in the packer while storage is full; only the completing beat must wait.
        assign wr_full   = full_mem && (pack_cnt == LAST_LANE);
        assign beat_acc  = wr_en && !wr_full;
        assign flush_acc = wr_flush && !full_mem && ((pack_cnt != '0) || beat_acc);
        assign commit    = (beat_acc && (pack_cnt == LAST_LANE)) || flush_acc;

        always_comb begin
            pack_nxt = pack_buf;
            if (beat_acc) pack_nxt[int'(pack_cnt)*NARROW_W +: NARROW_W] = wr_data;
        end

        assign commit_word = pack_nxt;
        assign pop         = rd_acc;
        assign rd_data     = rd_empty ? '0 : ram_q;

        // Clearing on commit leaves unfilled upper lanes zero for the next flush.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pack_cnt <= '0;
                pack_buf <= '0;
            end else if (commit) begin
                pack_cnt <= '0;
                pack_buf <= '0;
            end else if (beat_acc) begin
                pack_cnt <= pack_cnt + 1'b1;
                pack_buf <= pack_nxt;
            end
        end
    end else begin : gen_down
        logic [CW-1:0] unpack_cnt;
        logic          flush_unused;

        assign flush_unused = wr_flush;
        assign wr_full      = full_mem;
        assign commit       = wr_en && !full_mem;
        assign commit_word  = wr_data;
        assign pop          = rd_acc && (unpack_cnt == LAST_LANE);
        assign rd_data      = rd_empty ? '0 : ram_q[int'(unpack_cnt)*NARROW_W +: NARROW_W];

        always_ff @(posedge clk) begin
            if (!rst_n)      unpack_cnt <= '0;
            else if (rd_acc) unpack_cnt <= unpack_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (commit) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({commit, pop})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
            if (wr_en && wr_full)  overflow  <= 1'b1;
            if (rd_en && rd_empty) underflow <= 1'b1;
        end
    end

    width_conv_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDE_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit && rst_n),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (commit_word),
        .raddr (rd_addr_nxt),
        .rdata (ram_q)
    );

endmodule
